// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch/jump redirect controller and its pending-branch FIFO.
package branch_redirect_ctrl_pkg;

    // Decode descriptor kinds this block consumes.
    typedef enum logic [6:0] {
        B_TYPE = 7'b1100011,
        J_TYPE = 7'b1101111
    } bj_type_e;

    localparam logic FLUSH_FRONT = 1'b0;
    localparam logic FLUSH_ALL   = 1'b1;

    // Stored tags are zero-extended to this width so one entry type serves any TAG_W.
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REDIR_J,
        REDIR_B,
        FLUSH
    } redir_state_e;

    typedef struct packed {
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 resolved;
        logic                 taken;
    } bj_entry_t;

endpackage

// File: rtl/branch_redirect_ctrl_fifo.sv
// In-order FIFO of unresolved conditional branches with tag-matched resolve
// and a whole-queue clear.
module bj_pending_fifo
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enq,
    input  logic [TAG_W-1:0] enq_tag,
    input  logic [31:0]      enq_target,
    input  logic             deq,
    input  logic             res_en,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             full,
    output logic             head_resolved,
    output logic             head_taken,
    output logic [TAG_W-1:0] head_tag,
    output logic [31:0]      head_target,
    output logic [CNT_W-1:0] count
);

    bj_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // A freshly enqueued slot is not live yet, so a same-cycle result for it never hits.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = res_en & res_valid & live[i] & ~mem[i].resolved
                   & (mem[i].tag == TAG_MAX_W'(res_tag));
        end
    end

    // NOTE: the payload array has no reset; only the live bits and pointers need one,
    // since nothing reads a slot whose live bit is clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                mem[i].resolved <= 1'b1;
                mem[i].taken    <= res_taken;
            end
        end
        if (enq) begin
            mem[tail_ptr] <= '{tag: TAG_MAX_W'(enq_tag), target: enq_target,
                               resolved: 1'b0, taken: 1'b0};
        end
    end

    // NOTE: reset is synchronous, so it sits inside the clocked block as a plain condition.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            live     <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                live[tail_ptr] <= 1'b1;
                tail_ptr       <= tail_ptr + PTR_W'(1);
            end
            if (deq) begin
                live[head_ptr] <= 1'b0;
                head_ptr       <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    assign full          = (count == CNT_W'(DEPTH));
    assign head_resolved = live[head_ptr] & mem[head_ptr].resolved;
    assign head_taken    = mem[head_ptr].taken;
    assign head_tag      = mem[head_ptr].tag[TAG_W-1:0];
    assign head_target   = mem[head_ptr].target;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks decode-stage branches/jumps, retires resolved branches in order and
// drives the redirect/flush handshake toward a predict-not-taken fetch unit.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bj_valid,
    input  logic             branch,
    input  logic             jump,
    input  logic [31:0]      Branch_jump_addr,
    input  logic [TAG_W-1:0] bj_tag,
    output logic             bj_stall,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             flush_scope,
    output logic [TAG_W-1:0] flush_tag,
    output logic [CNT_W-1:0] pending_cnt
);

    redir_state_e     state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             scope_q, scope_d;

    logic             accept;
    logic             enq;
    logic             deq;
    logic             clear;
    logic             res_en;
    logic             retire_taken;
    logic             full;
    logic             head_resolved;
    logic             head_taken;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      head_target;

    bj_pending_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .enq           (enq),
        .enq_tag       (bj_tag),
        .enq_target    (Branch_jump_addr),
        .deq           (deq),
        .res_en        (res_en),
        .res_valid     (res_valid),
        .res_tag       (res_tag),
        .res_taken     (res_taken),
        .full          (full),
        .head_resolved (head_resolved),
        .head_taken    (head_taken),
        .head_tag      (head_tag),
        .head_target   (head_target),
        .count         (pending_cnt)
    );

    always_comb begin
        bj_stall     = (state_q != IDLE) | (branch & full);
        accept       = bj_valid & ~bj_stall;
        retire_taken = (state_q == IDLE) & head_resolved & head_taken;
        deq          = (state_q == IDLE) & head_resolved & ~head_taken;
        enq          = accept & branch;
        res_en       = (state_q != FLUSH);
        clear        = (state_q == FLUSH) & (scope_q == FLUSH_ALL);
    end

    // NOTE: every next-state variable gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tag_d    = tag_q;
        scope_d  = scope_q;
        unique case (state_q)
            IDLE: begin
                // An older taken branch kills any jump offered in the same cycle.
                if (retire_taken) begin
                    state_d  = REDIR_B;
                    target_d = head_target;
                    tag_d    = head_tag;
                    scope_d  = FLUSH_ALL;
                end else if (accept & jump) begin
                    state_d  = REDIR_J;
                    target_d = Branch_jump_addr;
                    tag_d    = bj_tag;
                    scope_d  = FLUSH_FRONT;
                end
            end
            REDIR_J, REDIR_B: begin
                if (redirect_ready) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            tag_q    <= '0;
            scope_q  <= FLUSH_FRONT;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            tag_q    <= tag_d;
            scope_q  <= scope_d;
        end
    end

    assign redirect_valid = (state_q == REDIR_J) | (state_q == REDIR_B);
    assign redirect_pc    = target_q;
    assign flush          = (state_q == FLUSH);
    assign flush_scope    = scope_q;
    assign flush_tag      = tag_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: queue-level reference model plus a flush scoreboard monitor.
module tb_branch_redirect_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam int M_IDLE  = 0;
    localparam int M_REDIR = 1;
    localparam int M_FLUSH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bj_valid = 1'b0;
    logic             branch = 1'b0;
    logic             jump = 1'b0;
    logic [31:0]      Branch_jump_addr = '0;
    logic [TAG_W-1:0] bj_tag = '0;
    logic             bj_stall;
    logic             res_valid = 1'b0;
    logic [TAG_W-1:0] res_tag = '0;
    logic             res_taken = 1'b0;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready = 1'b0;
    logic             flush;
    logic             flush_scope;
    logic [TAG_W-1:0] flush_tag;
    logic [CNT_W-1:0] pending_cnt;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bj_valid         (bj_valid),
        .branch           (branch),
        .jump             (jump),
        .Branch_jump_addr (Branch_jump_addr),
        .bj_tag           (bj_tag),
        .bj_stall         (bj_stall),
        .res_valid        (res_valid),
        .res_tag          (res_tag),
        .res_taken        (res_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .flush            (flush),
        .flush_scope      (flush_scope),
        .flush_tag        (flush_tag),
        .pending_cnt      (pending_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered list of pending branches and the redirect in progress.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        bit               resolved;
        bit               taken;
    } m_entry_t;

    typedef struct {
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
        bit               scope;
    } redir_t;

    m_entry_t mq[$];
    redir_t   sb[$];
    redir_t   cur;
    int       mode = M_IDLE;
    bit       after_reset = 1'b1;

    function automatic logic [TAG_W-1:0] free_tag();
        int start;
        start = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
            logic [TAG_W-1:0] t;
            bit used;
            t = TAG_W'((start + k) % 16);
            used = 1'b0;
            foreach (mq[i]) if (mq[i].tag == t) used = 1'b1;
            if (!used) return t;
        end
        return '0;
    endfunction

    task automatic step(input bit rst, input bit bv, input bit br, input bit jp,
                        input logic [31:0] addr, input logic [TAG_W-1:0] tg,
                        input bit rv, input logic [TAG_W-1:0] rt, input bit rtk,
                        input bit rdy);
        bit m_stall, accept, head_t, head_nt;
        @(negedge clk);
        rst_n            = !rst;
        bj_valid         = bv;
        branch           = br;
        jump             = jp;
        Branch_jump_addr = addr;
        bj_tag           = tg;
        res_valid        = rv;
        res_tag          = rt;
        res_taken        = rtk;
        redirect_ready   = rdy;
        m_stall = (mode != M_IDLE) || (br && mq.size() == DEPTH);
        #1;
        check("bj_stall", 32'(bj_stall), 32'(m_stall));
        check("pending_cnt", 32'(pending_cnt), 32'(mq.size()));
        check("redirect_valid", 32'(redirect_valid), 32'(mode == M_REDIR));
        check("flush", 32'(flush), 32'(mode == M_FLUSH));
        if (mode == M_REDIR) begin
            check("redirect_pc", redirect_pc, cur.pc);
            check("redirect_tag", 32'(flush_tag), 32'(cur.tag));
        end
        if (after_reset) begin
            check("reset_pc", redirect_pc, 32'h0);
            check("reset_tag", 32'(flush_tag), 32'h0);
            check("reset_scope", 32'(flush_scope), 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sb.delete();
            mode = M_IDLE;
            after_reset = 1'b1;
            return;
        end
        accept  = bv && !m_stall;
        head_t  = (mode == M_IDLE) && mq.size() > 0 && mq[0].resolved && mq[0].taken;
        head_nt = (mode == M_IDLE) && mq.size() > 0 && mq[0].resolved && !mq[0].taken;
        if (rv && mode != M_FLUSH) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].resolved && mq[i].tag == rt) begin
                    mq[i].resolved = 1'b1;
                    mq[i].taken    = rtk;
                    break;
                end
            end
        end
        case (mode)
            M_IDLE: begin
                if (head_t) begin
                    cur = '{pc: mq[0].target, tag: mq[0].tag, scope: 1'b1};
                    sb.push_back(cur);
                    mode = M_REDIR;
                    after_reset = 1'b0;
                end else begin
                    if (head_nt) void'(mq.pop_front());
                    if (accept && jp) begin
                        cur = '{pc: addr, tag: tg, scope: 1'b0};
                        sb.push_back(cur);
                        mode = M_REDIR;
                        after_reset = 1'b0;
                    end
                end
                if (accept && br) mq.push_back('{tag: tg, target: addr, resolved: 1'b0, taken: 1'b0});
            end
            M_REDIR: if (rdy) mode = M_FLUSH;
            default: begin
                if (cur.scope) mq.delete();
                mode = M_IDLE;
            end
        endcase
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic push_br(input logic [TAG_W-1:0] tg, input logic [31:0] addr);
        step(1'b0, 1'b1, 1'b1, 1'b0, addr, tg, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic resolve(input logic [TAG_W-1:0] tg, input bit taken, input bit rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1, tg, taken, rdy);
    endtask

    // Scoreboard monitor: every flush pulse must match the oldest predicted redirect.
    initial begin
        redir_t r;
        forever begin
            @(negedge clk);
            #2;
            if (flush === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL flush_unexpected: got flush_tag=0x%0h expected no flush", flush_tag);
                end else begin
                    r = sb.pop_front();
                    check("flush_tag", 32'(flush_tag), 32'(r.tag));
                    check("flush_scope", 32'(flush_scope), 32'(r.scope));
                    check("flush_pc", redirect_pc, r.pc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0, 1'b0);
        idle(1, 1'b0);

        // 1: reset while REDIR_B is stalled with three entries queued
        push_br(4'd1, 32'h0000_0a00);
        push_br(4'd2, 32'h0000_0b00);
        push_br(4'd3, 32'h0000_0c00);
        resolve(4'd1, 1'b1, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0, 1'b0);
        idle(2, 1'b1);

        // 2: single not-taken branch retires silently
        push_br(4'd3, 32'h0000_0100);
        resolve(4'd3, 1'b0, 1'b1);
        idle(3, 1'b1);

        // 3: younger resolves taken first; older not-taken retires, then redirect
        push_br(4'd1, 32'h0000_0200);
        push_br(4'd2, 32'h0000_0300);
        resolve(4'd2, 1'b1, 1'b1);
        resolve(4'd1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // 4: jump held under back-pressure, queued branch survives the front-end flush
        push_br(4'd7, 32'h0000_0700);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 4'd5, 1'b0, '0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        resolve(4'd7, 1'b0, 1'b1);
        idle(2, 1'b1);

        // 5: fill, stall on the fifth, then retire and enqueue in one cycle
        push_br(4'd8, 32'h0000_0800);
        push_br(4'd9, 32'h0000_0900);
        push_br(4'd10, 32'h0000_0a00);
        push_br(4'd11, 32'h0000_0b00);
        push_br(4'd12, 32'h0000_0c00);
        resolve(4'd8, 1'b0, 1'b1);
        push_br(4'd12, 32'h0000_0c00);
        resolve(4'd9, 1'b0, 1'b1);
        push_br(4'd12, 32'h0000_0c00);
        push_br(4'd13, 32'h0000_0d00);
        resolve(4'd10, 1'b0, 1'b1);
        resolve(4'd11, 1'b0, 1'b1);
        resolve(4'd12, 1'b0, 1'b1);
        resolve(4'd13, 1'b0, 1'b1);
        idle(4, 1'b1);

        // 6: taken head beats a same-cycle jump; unknown tag 9 is ignored
        push_br(4'd1, 32'h0000_1000);
        push_br(4'd4, 32'h0000_1400);
        resolve(4'd1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 4'd6, 1'b1, 4'd9, 1'b1, 1'b1);
        idle(5, 1'b1);

        for (int n = 0; n < 400; n++) begin
            bit bv, br, jp, rv, rtk, rdy;
            logic [31:0] addr;
            logic [TAG_W-1:0] tg, rt;
            bv   = ($urandom_range(0, 99) < 60);
            jp   = bv && ($urandom_range(0, 99) < 15);
            br   = bv && !jp;
            addr = $urandom() & 32'hffff_fffc;
            tg   = br ? free_tag() : TAG_W'($urandom_range(0, 15));
            rv   = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rt = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                rt = TAG_W'($urandom_range(0, 15));
            rtk  = ($urandom_range(0, 99) < 30);
            rdy  = ($urandom_range(0, 99) < 70);
            step(1'b0, bv, br, jp, addr, tg, rv, rt, rtk, rdy);
        end

        idle(8, 1'b1);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
